// File: rtl/uart_cfg_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_cfg_decoder_pkg
// Brief    : Shared constants for the UART configuration frame decoder.
// Revision : 1.0 - initial release
// ============================================================================
package uart_cfg_decoder_pkg;

    localparam logic [7:0] c_sync_byte = 8'hA5;

    localparam logic [2:0] c_err_none     = 3'd0;
    localparam logic [2:0] c_err_bad_addr = 3'd1;
    localparam logic [2:0] c_err_checksum = 3'd2;
    localparam logic [2:0] c_err_timeout  = 3'd3;
    localparam logic [2:0] c_err_rx       = 3'd4;
    localparam logic [2:0] c_err_overrun  = 3'd5;

    localparam int         c_state_w  = 3;
    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_addr  = 3'd1;
    localparam logic [2:0] c_st_data  = 3'd2;
    localparam logic [2:0] c_st_chk   = 3'd3;
    localparam logic [2:0] c_st_issue = 3'd4;

endpackage
`default_nettype wire

// File: rtl/uart_cfg_timeout.sv
`default_nettype none
// ============================================================================
// Module   : uart_cfg_timeout
// Brief    : Loadable up-counter watchdog with clear/enable and expired flag.
// Revision : 1.0 - initial release
// ============================================================================
module uart_cfg_timeout #(
    parameter int WIDTH_COUNT = 17,
    parameter int LIMIT       = 100000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   enable,
    input  logic                   load,
    input  logic [WIDTH_COUNT-1:0] load_value,
    output logic                   expired
);

    logic [WIDTH_COUNT-1:0] r_count;
    logic                   w_at_limit;

    assign w_at_limit = (r_count == WIDTH_COUNT'(LIMIT - 1));
    assign expired    = w_at_limit;

    // Saturates at the limit so a late clear still sees a stable flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (enable && !w_at_limit) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_cfg_decoder.sv
`default_nettype none
// ============================================================================
// Module   : uart_cfg_decoder
// Brief    : Turns sync/addr/data/checksum byte frames into config bus writes.
// Revision : 1.0 - initial release
// ============================================================================
module uart_cfg_decoder
    import uart_cfg_decoder_pkg::*;
#(
    parameter int                        WIDTH_DATABITS    = 8,
    parameter int                        WIDTH_CONFIG_ADDR = 4,
    parameter int                        WIDTH_CONFIG_DATA = 16,
    parameter logic [WIDTH_DATABITS-1:0] SYNC_BYTE         = c_sync_byte,
    parameter int                        TIMEOUT_CYCLES    = 100000,
    parameter int                        WIDTH_DEC_ERROR   = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WIDTH_DATABITS-1:0]    rx_data,
    input  logic                         rx_valid,
    input  logic                         rx_error_valid,
    output logic [WIDTH_CONFIG_ADDR-1:0] c_addr,
    output logic [WIDTH_CONFIG_DATA-1:0] c_data,
    output logic                         c_valid,
    input  logic                         c_ready,
    output logic [WIDTH_DEC_ERROR-1:0]   dec_error,
    output logic                         dec_error_valid
);

    localparam int NUM_DATA_BYTES = WIDTH_CONFIG_DATA / WIDTH_DATABITS;
    localparam int CNT_W          = $clog2(NUM_DATA_BYTES) + 1;
    localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_state_w-1:0]         r_state, w_state_nxt;
    logic [WIDTH_CONFIG_ADDR-1:0] r_addr, w_addr_nxt;
    logic [WIDTH_CONFIG_DATA-1:0] r_data, w_data_nxt, w_data_shift;
    logic [WIDTH_DATABITS-1:0]    r_chk, w_chk_nxt;
    logic [CNT_W-1:0]             r_cnt, w_cnt_nxt;
    logic [WIDTH_DEC_ERROR-1:0]   r_err;
    logic                         r_err_valid;
    logic                         w_err_fire;
    logic [2:0]                   w_err_code;
    logic                         w_in_frame;
    logic                         w_expired;

    generate
        if (WIDTH_CONFIG_DATA > WIDTH_DATABITS) begin : g_shift_wide
            assign w_data_shift = {r_data[WIDTH_CONFIG_DATA-WIDTH_DATABITS-1:0], rx_data};
        end else begin : g_shift_byte
            assign w_data_shift = rx_data;
        end
    endgenerate

    assign w_in_frame = (r_state == c_st_addr) || (r_state == c_st_data) ||
                        (r_state == c_st_chk);

    uart_cfg_timeout #(
        .WIDTH_COUNT (TO_W),
        .LIMIT       (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (rx_valid || !w_in_frame),
        .enable     (w_in_frame),
        .load       (1'b0),
        .load_value ('0),
        .expired    (w_expired)
    );

    // Receiver errors take priority over a byte, a byte over a timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_chk_nxt   = r_chk;
        w_cnt_nxt   = r_cnt;
        w_err_fire  = 1'b0;
        w_err_code  = c_err_none;
        case (r_state)
            c_st_idle: begin
                if (rx_valid && !rx_error_valid && (rx_data == SYNC_BYTE)) begin
                    w_state_nxt = c_st_addr;
                end
            end
            c_st_addr, c_st_data, c_st_chk: begin
                if (rx_error_valid) begin
                    w_err_fire  = 1'b1;
                    w_err_code  = c_err_rx;
                    w_state_nxt = c_st_idle;
                end else if (rx_valid) begin
                    if (r_state == c_st_addr) begin
                        w_addr_nxt = rx_data[WIDTH_CONFIG_ADDR-1:0];
                        w_chk_nxt  = rx_data;
                        w_cnt_nxt  = '0;
                        if ((rx_data >> WIDTH_CONFIG_ADDR) != '0) begin
                            w_err_fire  = 1'b1;
                            w_err_code  = c_err_bad_addr;
                            w_state_nxt = c_st_idle;
                        end else begin
                            w_state_nxt = c_st_data;
                        end
                    end else if (r_state == c_st_data) begin
                        w_data_nxt = w_data_shift;
                        w_chk_nxt  = r_chk ^ rx_data;
                        if (r_cnt == CNT_W'(NUM_DATA_BYTES - 1)) begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = c_st_chk;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end else begin
                        if (rx_data == r_chk) begin
                            w_state_nxt = c_st_issue;
                        end else begin
                            w_err_fire  = 1'b1;
                            w_err_code  = c_err_checksum;
                            w_state_nxt = c_st_idle;
                        end
                    end
                end else if (w_expired) begin
                    w_err_fire  = 1'b1;
                    w_err_code  = c_err_timeout;
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_issue: begin
                if (rx_valid) begin
                    w_err_fire = 1'b1;
                    w_err_code = c_err_overrun;
                end
                if (c_ready) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_addr      <= '0;
            r_data      <= '0;
            r_chk       <= '0;
            r_cnt       <= '0;
            r_err       <= '0;
            r_err_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_data      <= w_data_nxt;
            r_chk       <= w_chk_nxt;
            r_cnt       <= w_cnt_nxt;
            r_err_valid <= w_err_fire;
            if (w_err_fire) begin
                r_err <= WIDTH_DEC_ERROR'(w_err_code);
            end
        end
    end

    // Decoded from state so the asynchronous reset drops it immediately.
    assign c_valid         = (r_state == c_st_issue);
    assign c_addr          = r_addr;
    assign c_data          = r_data;
    assign dec_error       = r_err;
    assign dec_error_valid = r_err_valid;

endmodule
`default_nettype wire

// File: tb/tb_uart_cfg_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cfg_decoder
// Brief    : Directed self-checking bench for uart_cfg_decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cfg_decoder;

    localparam int TO_CYC = 50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_error_valid = 1'b0;
    logic [3:0]  c_addr;
    logic [15:0] c_data;
    logic        c_valid;
    logic        c_ready = 1'b1;
    logic [2:0]  dec_error;
    logic        dec_error_valid;

    int n_total = 0;
    int n_bad   = 0;

    int          mon_writes = 0;
    int          mon_vcycles = 0;
    int          mon_errs = 0;
    logic [3:0]  mon_addr = '0;
    logic [15:0] mon_data = '0;
    logic [2:0]  mon_err = '0;

    int w0, v0, e0;

    uart_cfg_decoder #(
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_error_valid  (rx_error_valid),
        .c_addr          (c_addr),
        .c_data          (c_data),
        .c_valid         (c_valid),
        .c_ready         (c_ready),
        .dec_error       (dec_error),
        .dec_error_valid (dec_error_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n) begin
            if (c_valid) mon_vcycles <= mon_vcycles + 1;
            if (c_valid && c_ready) begin
                mon_writes <= mon_writes + 1;
                mon_addr   <= c_addr;
                mon_data   <= c_data;
            end
            if (dec_error_valid) begin
                mon_errs <= mon_errs + 1;
                mon_err  <= dec_error;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        w0 = mon_writes;
        v0 = mon_vcycles;
        e0 = mon_errs;
    endtask

    initial begin
        // Reset state
        idle(3);
        check("rst_c_valid", 32'(c_valid), 0);
        check("rst_err_valid", 32'(dec_error_valid), 0);
        check("rst_err", 32'(dec_error), 0);
        check("rst_addr_data", {12'h0, c_addr, c_data}, 0);
        rst_n = 1'b1;
        idle(2);

        // Basic frame, ready always high
        snap();
        c_ready = 1'b1;
        send_byte(8'hA5); send_byte(8'h05); send_byte(8'h12); send_byte(8'h34); send_byte(8'h23);
        check("basic_c_valid_next", 32'(c_valid), 1);
        idle(4);
        check("basic_writes", 32'(mon_writes - w0), 1);
        check("basic_vcycles", 32'(mon_vcycles - v0), 1);
        check("basic_addr", 32'(mon_addr), 32'h5);
        check("basic_data", 32'(mon_data), 32'h1234);
        check("basic_no_err", 32'(mon_errs - e0), 0);

        // Back-pressure for 10 cycles
        snap();
        c_ready = 1'b0;
        send_byte(8'hA5); send_byte(8'h09); send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h6F);
        idle(10);
        check("bp_held", 32'(c_valid), 1);
        check("bp_stable", {12'h0, c_addr, c_data}, 32'h0009ABCD);
        c_ready = 1'b1;
        idle(3);
        check("bp_vcycles", 32'(mon_vcycles - v0), 11);
        check("bp_writes", 32'(mon_writes - w0), 1);
        check("bp_wr_val", {12'h0, mon_addr, mon_data}, 32'h0009ABCD);

        // Bad checksum then recovery
        snap();
        send_byte(8'hA5); send_byte(8'h05); send_byte(8'h12); send_byte(8'h34); send_byte(8'h00);
        idle(3);
        check("chk_err_cnt", 32'(mon_errs - e0), 1);
        check("chk_err_code", 32'(mon_err), 2);
        check("chk_no_write", 32'(mon_writes - w0), 0);
        check("chk_err_hold", 32'(dec_error), 2);
        send_byte(8'hA5); send_byte(8'h05); send_byte(8'h12); send_byte(8'h34); send_byte(8'h23);
        idle(3);
        check("recov_write", {12'h0, mon_addr, mon_data}, 32'h00051234);
        check("recov_writes", 32'(mon_writes - w0), 1);

        // Bad address
        snap();
        send_byte(8'hA5); send_byte(8'h15);
        idle(3);
        check("badaddr_code", 32'(mon_err), 1);
        check("badaddr_cnt", 32'(mon_errs - e0), 1);

        // Inter-byte timeout
        snap();
        send_byte(8'hA5); send_byte(8'h05); send_byte(8'h12);
        idle(TO_CYC - 10);
        check("to_not_early", 32'(mon_errs - e0), 0);
        idle(20);
        check("to_cnt", 32'(mon_errs - e0), 1);
        check("to_code", 32'(mon_err), 3);

        // Receiver error mid-frame, simultaneous with a byte
        snap();
        send_byte(8'hA5); send_byte(8'h05);
        @(negedge clk);
        rx_error_valid = 1'b1;
        rx_valid = 1'b1;
        rx_data = 8'h12;
        @(negedge clk);
        rx_error_valid = 1'b0;
        rx_valid = 1'b0;
        idle(3);
        check("rxerr_code", 32'(mon_err), 4);
        check("rxerr_cnt", 32'(mon_errs - e0), 1);
        check("rxerr_no_write", 32'(mon_writes - w0), 0);

        // Junk before sync, then overrun during a held write
        snap();
        c_ready = 1'b0;
        send_byte(8'h00); send_byte(8'hFF);
        send_byte(8'hA5); send_byte(8'h06); send_byte(8'h00); send_byte(8'h01); send_byte(8'h07);
        idle(2);
        send_byte(8'h42);
        idle(2);
        check("ovr_code", 32'(mon_err), 5);
        check("ovr_still_valid", 32'(c_valid), 1);
        c_ready = 1'b1;
        idle(3);
        check("ovr_write", {12'h0, mon_addr, mon_data}, 32'h00060001);
        check("ovr_writes", 32'(mon_writes - w0), 1);
        check("ovr_err_cnt", 32'(mon_errs - e0), 1);

        // Asynchronous reset mid-handshake
        c_ready = 1'b0;
        send_byte(8'hA5); send_byte(8'h05); send_byte(8'h12); send_byte(8'h34); send_byte(8'h23);
        idle(2);
        check("pre_rst_valid", 32'(c_valid), 1);
        #2 rst_n = 1'b0;
        #1 check("async_rst_valid", 32'(c_valid), 0);
        check("async_rst_addr", {12'h0, c_addr, c_data}, 0);
        idle(2);
        rst_n = 1'b1;
        c_ready = 1'b1;
        idle(2);
        snap();
        send_byte(8'hA5); send_byte(8'h0A); send_byte(8'h55); send_byte(8'hAA); send_byte(8'hF5);
        idle(3);
        check("post_rst_write", {12'h0, mon_addr, mon_data}, 32'h000A55AA);
        check("post_rst_writes", 32'(mon_writes - w0), 1);
        check("post_rst_no_err", 32'(mon_errs - e0), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_cfg_decoder.md
Name: uart_cfg_decoder

Overview:
- Sits directly downstream of the UART receiver and consumes its received bytes (rx_data/rx_valid) and error pulses (rx_error_valid).
- Assembles fixed-format configuration frames from the byte stream: sync, address, data bytes MSB first, XOR checksum.
- Each valid frame becomes one write on the configuration bus (c_addr/c_data/c_valid/c_ready) that feeds the UART and VGA configuration blocks.
- Reports framing faults through an error code with a one-cycle valid strobe.

Parameters:
- WIDTH_DATABITS, 8, width of a received UART byte (fixed 8).
- WIDTH_CONFIG_ADDR, 4, config bus address width (01xx UART, 10xx VGA).
- WIDTH_CONFIG_DATA, 16, config bus data width; must be a multiple of 8; sent MSB byte first.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 100000, maximum idle clk cycles between bytes inside a frame.
- WIDTH_DEC_ERROR, 3, width of the error code.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rx_data  input  WIDTH_DATABITS  received byte
- rx_valid  input  1  one-cycle strobe, rx_data valid
- rx_error_valid  input  1  one-cycle strobe, receiver detected parity/stop error
- c_addr  output  WIDTH_CONFIG_ADDR  config address
- c_data  output  WIDTH_CONFIG_DATA  config data
- c_valid  output  1  config write request
- c_ready  input  1  config bus free
- dec_error  output  WIDTH_DEC_ERROR  error code
- dec_error_valid  output  1  one-cycle strobe, dec_error meaningful

Behaviour:
- Reset: all outputs 0, state IDLE, byte counter 0, timeout counter 0, checksum 0. Reset applies immediately, mid-frame or mid-handshake; c_valid drops asynchronously.
- States and transitions:
  - IDLE: wait for rx_valid. If byte == SYNC_BYTE, go to ADDR; any other byte is silently discarded.
  - ADDR: on rx_valid, latch byte[WIDTH_CONFIG_ADDR-1:0] and set chk = byte.
    - If byte[7:WIDTH_CONFIG_ADDR] != 0, raise error 3'd1 (BAD_ADDR) and return to IDLE.
    - Otherwise go to DATA.
  - DATA: on each rx_valid, shift the byte into the data register (MSB first) and set chk ^= byte. After WIDTH_CONFIG_DATA/8 bytes, go to CHK.
  - CHK: on rx_valid, if byte == chk go to ISSUE; else raise error 3'd2 (CHECKSUM) and return to IDLE.
  - ISSUE: c_valid=1 with c_addr/c_data stable. The write completes in the cycle where c_valid && c_ready; c_valid drops the next cycle and the state returns to IDLE. c_valid asserts the cycle after the checksum byte is accepted.
- Timeout:
  - The counter runs only in ADDR/DATA/CHK and clears on every rx_valid.
  - On reaching TIMEOUT_CYCLES-1 without a byte, raise 3'd3 (TIMEOUT) and return to IDLE.
  - ISSUE has no timeout; c_valid holds until c_ready.
- Receiver error: rx_error_valid in ADDR/DATA/CHK raises 3'd4 (RX_ERROR) and returns to IDLE. In IDLE it is ignored. In ISSUE it does not disturb the pending write.
- Overrun: rx_valid during ISSUE drops the byte and raises 3'd5 (OVERRUN). The pending write is unaffected, and the dropped byte is not checked for sync.
- Simultaneous events:
  - rx_error_valid and rx_valid in the same cycle: the error wins and the byte is discarded.
  - A timeout and rx_valid in the same cycle: the byte wins.
- dec_error_valid is a one-cycle pulse, registered one cycle after the triggering event. dec_error holds its last code until the next error.
- Checksum is an 8-bit XOR of the address byte and all data bytes; the sync byte is excluded.

Decomposition:
- Shared package/header (next to the UART and CS params): SYNC_BYTE, error code constants (ERR_BAD_ADDR=1, ERR_CHECKSUM=2, ERR_TIMEOUT=3, ERR_RX=4, ERR_OVERRUN=5), state encoding.
- One sub-module, uart_cfg_timeout: a loadable counter with clear and enable inputs and an expired output, reusable for other inter-byte watchdogs.

Test Plan:
- Bytes A5,05,12,34,23, c_ready=1 -> one write, c_addr=4'h5, c_data=16'h1234, c_valid high for exactly 1 cycle, no error.
- Bytes A5,09,AB,CD,6F with c_ready=0 for 10 cycles, then 1 -> c_valid held 11 cycles with stable addr/data, single write to 4'h9 data 16'hABCD.
- Bytes A5,05,12,34,00 -> dec_error=2 pulse, no c_valid. A following A5,05,12,34,23 -> correct write (recovery).
- Bytes A5,15 -> dec_error=1. A5,05,12 then 100000 idle cycles -> dec_error=3. A5,05 then rx_error_valid -> dec_error=4. All return to IDLE with no write.
- Bytes 00,FF,A5,06,00,01,07 -> junk ignored, write addr 4'h6 data 16'h0001. During the held c_valid, inject rx_valid 8'h42 -> dec_error=5, write still completes.
- Assert rst_n=0 mid-ISSUE -> c_valid=0 immediately. After release, the state is IDLE and a fresh frame is decoded normally.
